// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, 8 x 16-bit register file (r0 reads 0) and committed-writeback counter.
// Build option: define WB_BYPASS_EN to forward wb_data to a read port that matches the committing index.
module wb_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        regWrite_in,
   input  logic        memtoReg_in,
   input  logic [2:0]  write_reg_in,
   input  logic [15:0] mem_data_in,
   input  logic [15:0] alu_result_in,
   input  logic [2:0]  read_reg1,
   input  logic [2:0]  read_reg2,
   output logic [15:0] read_data1,
   output logic [15:0] read_data2,
   output logic [15:0] wb_data,
   output logic        wb_commit,
   output logic [15:0] retire_count
);

   logic [15:0] rf [0:7];
   logic [15:0] retire_q, retire_d;

   assign wb_data   = memtoReg_in ? mem_data_in : alu_result_in;
   assign wb_commit = en & regWrite_in & (write_reg_in != 3'd0);

   // r0 has no storage; its read slot is tied to zero.
   assign rf[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_reg
         logic [15:0] reg_q, reg_d;

         always_comb begin
            reg_d = reg_q;
            if (wb_commit && (write_reg_in == 3'(gi)))
               reg_d = wb_data;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               reg_q <= '0;
            else
               reg_q <= reg_d;
         end

         assign rf[gi] = reg_q;
      end
   endgenerate

`ifdef WB_BYPASS_EN
   // wb_commit already excludes index 0, so a match here is always a real register.
   assign read_data1 = (wb_commit && (read_reg1 == write_reg_in)) ? wb_data : rf[read_reg1];
   assign read_data2 = (wb_commit && (read_reg2 == write_reg_in)) ? wb_data : rf[read_reg2];
`else
   assign read_data1 = rf[read_reg1];
   assign read_data2 = rf[read_reg2];
`endif

   always_comb begin
      retire_d = retire_q;
      if (wb_commit)
         retire_d = retire_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_q <= '0;
      else
         retire_q <= retire_d;
   end

   assign retire_count = retire_q;

endmodule
